// File: rtl/sync_fifo_pkg.sv
// Shared constants and pointer type for the single-clock FWFT command FIFO.
package sync_fifo_pkg;

  localparam int unsigned DEF_DATA_WIDTH      = 592;
  localparam int unsigned DEF_DEPTH           = 8192;
  localparam int unsigned DEF_RST_BUSY_CYCLES = 4;
  localparam int unsigned ADDR_W              = $clog2(DEF_DEPTH);

  // Address plus one wrap bit, so full and empty are distinguishable.
  typedef logic [ADDR_W:0] ptr_t;

endpackage

// File: rtl/sync_fifo_ram.sv
// Simple dual-port RAM with a one-cycle registered read; the read register is the FWFT output stage.
module sync_fifo_ram #(
  parameter int unsigned DATA_WIDTH = 592,
  parameter int unsigned DEPTH      = 8192
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata_q <= '0;
    else if (re) rdata_q <= mem[raddr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sync_fwft_fifo.sv
// Single-clock first-word-fall-through FIFO with reset-busy handshake.
// Define SYNC_FIFO_COUNT_EN to drive wr_data_count/rd_data_count from an occupancy counter.
module sync_fwft_fifo
  import sync_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int unsigned DEPTH           = DEF_DEPTH,
  parameter int unsigned RST_BUSY_CYCLES = DEF_RST_BUSY_CYCLES
) (
  input  logic                     axis_clk,
  input  logic                     axis_rstn,
  input  logic                     wr_en,
  input  logic [DATA_WIDTH-1:0]    din,
  input  logic                     rd_en,
  output logic [DATA_WIDTH-1:0]    dout,
  output logic                     empty,
  output logic                     full,
  output logic                     data_valid,
  output logic                     wr_ack,
  output logic                     overflow,
  output logic                     underflow,
  output logic [$clog2(DEPTH):0]   wr_data_count,
  output logic [$clog2(DEPTH):0]   rd_data_count,
  output logic                     wr_rst_busy,
  output logic                     rd_rst_busy
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned BUSY_W = (RST_BUSY_CYCLES < 2) ? 1 : $clog2(RST_BUSY_CYCLES + 1);
  localparam logic [AW:0]       PTR_ONE  = (AW + 1)'(1);
  localparam logic [BUSY_W-1:0] BUSY_ONE = BUSY_W'(1);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic              out_valid_q, out_valid_d;
  logic              wr_ack_q, overflow_q, underflow_q;
  logic [BUSY_W-1:0] busy_cnt_q, busy_cnt_d;

  logic busy, wr_acc, rd_acc, ram_has, refill, full_w;

`ifdef SYNC_FIFO_COUNT_EN
  logic [AW:0] count_q, count_d;
  assign full_w = (count_q == (AW + 1)'(DEPTH));
`else
  // Logical head pointer: advances on each pop, so wr_ptr - head = total occupancy.
  logic [AW:0] head_ptr_q, head_ptr_d;
  assign full_w = ((wr_ptr_q ^ head_ptr_q) == {1'b1, {AW{1'b0}}});
`endif

  always_comb begin
    busy    = (busy_cnt_q != '0);
    wr_acc  = wr_en & ~full_w & ~busy;
    rd_acc  = rd_en & out_valid_q & ~busy;
    ram_has = (rd_ptr_q != wr_ptr_q);
    // Output register refills from RAM when empty or being popped this edge.
    refill  = ram_has & (~out_valid_q | rd_acc);

    wr_ptr_d    = wr_acc ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d    = refill ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    out_valid_d = refill | (out_valid_q & ~rd_acc);
    busy_cnt_d  = busy ? busy_cnt_q - BUSY_ONE : busy_cnt_q;
  end

`ifdef SYNC_FIFO_COUNT_EN
  always_comb begin
    count_d = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge axis_clk or posedge axis_rstn) begin
    if (axis_rstn) count_q <= '0;
    else           count_q <= count_d;
  end

  assign wr_data_count = count_q;
  assign rd_data_count = count_q;
`else
  always_comb begin
    head_ptr_d = rd_acc ? head_ptr_q + PTR_ONE : head_ptr_q;
  end

  always_ff @(posedge axis_clk or posedge axis_rstn) begin
    if (axis_rstn) head_ptr_q <= '0;
    else           head_ptr_q <= head_ptr_d;
  end

  assign wr_data_count = '0;
  assign rd_data_count = '0;
`endif

  always_ff @(posedge axis_clk or posedge axis_rstn) begin
    if (axis_rstn) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      wr_ack_q    <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
      busy_cnt_q  <= BUSY_W'(RST_BUSY_CYCLES);
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      out_valid_q <= out_valid_d;
      wr_ack_q    <= wr_acc;
      overflow_q  <= wr_en & full_w;
      underflow_q <= rd_en & ~out_valid_q;
      busy_cnt_q  <= busy_cnt_d;
    end
  end

  sync_fifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_ram (
    .clk   (axis_clk),
    .rst   (axis_rstn),
    .we    (wr_acc),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (din),
    .re    (refill),
    .raddr (rd_ptr_q[AW-1:0]),
    .rdata (dout)
  );

  assign empty       = ~out_valid_q;
  assign data_valid  = out_valid_q;
  assign full        = full_w;
  assign wr_ack      = wr_ack_q;
  assign overflow    = overflow_q;
  assign underflow   = underflow_q;
  assign wr_rst_busy = busy;
  assign rd_rst_busy = busy;

endmodule

// File: tb/tb_sync_fwft_fifo.sv
// Directed self-checking bench for sync_fwft_fifo at default parameters.
module tb_sync_fwft_fifo;

  localparam int unsigned DW    = 592;
  localparam int unsigned DEPTH = 8192;
  localparam int unsigned CW    = 14;
`ifdef SYNC_FIFO_COUNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          axis_clk = 1'b0;
  logic          axis_rstn;
  logic          wr_en, rd_en;
  logic [DW-1:0] din, dout;
  logic          empty, full, data_valid, wr_ack, overflow, underflow;
  logic [CW-1:0] wr_data_count, rd_data_count;
  logic          wr_rst_busy, rd_rst_busy;

  int unsigned n_pass = 0;
  int unsigned n_fail = 0;
  int unsigned n_total = 0;

  always #5 axis_clk = ~axis_clk;

  sync_fwft_fifo #(
    .DATA_WIDTH      (DW),
    .DEPTH           (DEPTH),
    .RST_BUSY_CYCLES (4)
  ) dut (
    .axis_clk      (axis_clk),
    .axis_rstn     (axis_rstn),
    .wr_en         (wr_en),
    .din           (din),
    .rd_en         (rd_en),
    .dout          (dout),
    .empty         (empty),
    .full          (full),
    .data_valid    (data_valid),
    .wr_ack        (wr_ack),
    .overflow      (overflow),
    .underflow     (underflow),
    .wr_data_count (wr_data_count),
    .rd_data_count (rd_data_count),
    .wr_rst_busy   (wr_rst_busy),
    .rd_rst_busy   (rd_rst_busy)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_cnt(input int n);
    return CNT_EN ? DW'(n) : '0;
  endfunction

  task automatic chk_cnt(input string tag, input int n);
    chk({tag, "_wcnt"}, DW'(wr_data_count), exp_cnt(n));
    chk({tag, "_rcnt"}, DW'(rd_data_count), exp_cnt(n));
  endtask

  task automatic step();
    @(posedge axis_clk);
    #1;
  endtask

  initial begin
    axis_rstn = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din = '0;
    step();
    step();

    // reset state
    chk("rst_empty", DW'(empty), DW'(1));
    chk("rst_dvalid", DW'(data_valid), DW'(0));
    chk("rst_full", DW'(full), DW'(0));
    chk("rst_dout", dout, '0);
    chk("rst_wbusy", DW'(wr_rst_busy), DW'(1));
    chk("rst_rbusy", DW'(rd_rst_busy), DW'(1));
    chk("rst_wr_ack", DW'(wr_ack), DW'(0));
    chk("rst_ovf", DW'(overflow), DW'(0));
    chk("rst_unf", DW'(underflow), DW'(0));
    chk_cnt("rst", 0);

    axis_rstn = 1'b0;
    step(); step(); step();
    chk("busy_3", DW'(wr_rst_busy), DW'(1));
    step();
    chk("busy_4_w", DW'(wr_rst_busy), DW'(0));
    chk("busy_4_r", DW'(rd_rst_busy), DW'(0));
    chk("idle_empty", DW'(empty), DW'(1));
    chk("idle_dout", dout, '0);

    // single word latency
    wr_en = 1'b1;
    din = DW'(32'h1234);
    step();
    wr_en = 1'b0;
    chk("t0_empty", DW'(empty), DW'(1));
    chk("t0_wr_ack", DW'(wr_ack), DW'(1));
    chk_cnt("t0", 1);
    step();
    chk("t1_empty", DW'(empty), DW'(0));
    chk("t1_dvalid", DW'(data_valid), DW'(1));
    chk("t1_dout", dout, DW'(32'h1234));
    chk("t1_wr_ack", DW'(wr_ack), DW'(0));
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("pop_empty", DW'(empty), DW'(1));
    chk("pop_stale", dout, DW'(32'h1234));
    chk("pop_unf", DW'(underflow), DW'(0));
    chk_cnt("pop", 0);

    // underflow
    rd_en = 1'b1;
    step();
    rd_en = 1'b0;
    chk("unf_pulse", DW'(underflow), DW'(1));
    chk("unf_empty", DW'(empty), DW'(1));
    chk("unf_dout", dout, DW'(32'h1234));
    chk_cnt("unf", 0);
    step();
    chk("unf_clear", DW'(underflow), DW'(0));

    // fill to full
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (i == int'(DEPTH) - 1) chk("not_full_yet", DW'(full), DW'(0));
      wr_en = 1'b1;
      din = DW'(i);
      step();
    end
    chk("full_set", DW'(full), DW'(1));
    chk_cnt("full", int'(DEPTH));
    din = DW'(32'hDEAD);
    step();
    wr_en = 1'b0;
    chk("ovf_pulse", DW'(overflow), DW'(1));
    chk("ovf_no_ack", DW'(wr_ack), DW'(0));
    chk("ovf_full", DW'(full), DW'(1));
    chk_cnt("ovf", int'(DEPTH));
    chk("ovf_head", dout, '0);

    // pop and write while full: write rejected
    wr_en = 1'b1;
    rd_en = 1'b1;
    din = DW'(32'hBEEF);
    step();
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("fullrw_ovf", DW'(overflow), DW'(1));
    chk("fullrw_full", DW'(full), DW'(0));
    chk("fullrw_dout", dout, DW'(1));
    chk_cnt("fullrw", int'(DEPTH) - 1);

    rd_en = 1'b1;
    for (int i = 1; i < int'(DEPTH); i++) begin
      chk("drain_dout", dout, DW'(i));
      step();
    end
    rd_en = 1'b0;
    chk("drain_empty", DW'(empty), DW'(1));
    chk("drain_stale", dout, DW'(DEPTH - 1));
    chk("drain_full", DW'(full), DW'(0));
    chk_cnt("drain", 0);

    // steady-state read+write at occupancy 5
    wr_en = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = DW'(100 + i);
      step();
    end
    rd_en = 1'b1;
    for (int k = 0; k < 100; k++) begin
      din = DW'(105 + k);
      chk("rw_dout", dout, DW'(100 + k));
      step();
    end
    wr_en = 1'b0;
    rd_en = 1'b0;
    chk("rw_end_dout", dout, DW'(200));
    chk("rw_end_empty", DW'(empty), DW'(0));
    chk_cnt("rw_end", 5);

    // reset with 100 words stored
    wr_en = 1'b1;
    for (int j = 0; j < 95; j++) begin
      din = DW'(300 + j);
      step();
    end
    wr_en = 1'b0;
    chk_cnt("pre_rst", 100);
    chk("pre_rst_dout", dout, DW'(200));
    axis_rstn = 1'b1;
    #1;
    chk("mid_rst_empty", DW'(empty), DW'(1));
    chk("mid_rst_dout", dout, '0);
    chk("mid_rst_wbusy", DW'(wr_rst_busy), DW'(1));
    chk("mid_rst_rbusy", DW'(rd_rst_busy), DW'(1));
    chk_cnt("mid_rst", 0);
    step();
    axis_rstn = 1'b0;
    step(); step(); step(); step();
    chk("post_rst_busy", DW'(wr_rst_busy), DW'(0));
    chk("post_rst_empty", DW'(empty), DW'(1));
    chk("post_rst_dout", dout, '0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
